// File: rtl/cpld_ram_multipage_pkg.sv
// Shared types and constants for the CPC RAM expansion controller.
// Provides the memory-cycle state enum, mode codes and field widths.
package cpld_ram_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MRD,
      ST_MWR,
      ST_HOLD
   } state_t;

   localparam logic [2:0] MODE_C3 = 3'd3;
   localparam logic [7:0] IO_BASE = 8'h7F;
   localparam int         BANK_W  = 3;
   localparam int         BLK_W   = 2;

   function automatic int pb_of(input int n);
      return (n > 1) ? $clog2(n) : 0;
   endfunction

endpackage

// File: rtl/cpld_ram_multipage_if.sv
// Z80-side bus and SRAM-side outputs of the RAM expansion controller.
// master: CPU/bus model drives the Z80 pins; slave: the controller.
interface cpld_ram_multipage_if #(
   parameter int PB = 1
);
   logic [15:0]   adr;
   logic [7:0]    data;
   logic          iorq_b;
   logic          mreq_b;
   logic          rfsh_b;
   logic          m1_b;
   logic          wr_b;
   logic          rd_b;
   logic [4+PB:0] ramadrhi;
   logic          ramcs_b;
   logic          ramdis;
   logic          rd_b_od;
   logic          adr15_od;
   logic [5+PB:0] cfg_q;

   modport master (
      output adr, data, iorq_b, mreq_b, rfsh_b, m1_b, wr_b, rd_b,
      input  ramadrhi, ramcs_b, ramdis, rd_b_od, adr15_od, cfg_q
   );

   modport slave (
      input  adr, data, iorq_b, mreq_b, rfsh_b, m1_b, wr_b, rd_b,
      output ramadrhi, ramcs_b, ramdis, rd_b_od, adr15_od, cfg_q
   );
endinterface

// File: rtl/cpld_ram_bank_decode.sv
// Combinational map of {mode,bank,page,a15,a14} to SRAM hit/address.
// Ports: i_mode,i_bank,i_page,i_a15,i_a14 -> o_hit,o_adrhi,o_a15_od.
module cpld_ram_bank_decode
   import cpld_ram_pkg::*;
#(
   parameter int PB = 1
) (
   input  logic [2:0]              i_mode,
   input  logic [BANK_W-1:0]       i_bank,
   input  logic [(PB>0?PB:1)-1:0]  i_page,
   input  logic                    i_a15,
   input  logic                    i_a14,
   output logic                    o_hit,
   output logic [4+PB:0]           o_adrhi,
   output logic                    o_a15_od
);

   logic [BLK_W-1:0] w_blk;

   always_comb begin
      o_hit    = 1'b0;
      o_a15_od = 1'b0;
      w_blk    = '0;
      unique case (1'b1)
         (i_mode == 3'd1): begin
            if (i_a15 && i_a14) begin
               o_hit = 1'b1;
               w_blk = 2'd3;
            end
         end
         (i_mode == 3'd2): begin
            o_hit = 1'b1;
            w_blk = {i_a15, i_a14};
         end
         (i_mode == MODE_C3): begin
            if (i_a15 && i_a14) begin
               o_hit = 1'b1;
               w_blk = 2'd3;
            end else if (!i_a15 && i_a14) begin
               // 464 trick: force CPU to see 0xC000 internally
               o_a15_od = 1'b1;
            end
         end
         i_mode[2]: begin
            if (!i_a15 && i_a14) begin
               o_hit = 1'b1;
               w_blk = i_mode[1:0];
            end
         end
         default: begin
         end
      endcase
   end

   generate
      if (PB > 0) begin : g_pg
         assign o_adrhi = {i_page, i_bank, w_blk};
      end else begin : g_nopg
         logic w_unused_pg;
         assign w_unused_pg = &{1'b0, i_page};
         assign o_adrhi = {i_bank, w_blk};
      end
   endgenerate

endmodule

// File: rtl/cpld_ram_multipage.sv
// CPC RAM expansion controller: IO bank-write decode, memory FSM, SRAM ctl.
// Ports: clk, reset, bus (slave modport: Z80 pins in, SRAM/od/cfg out).
module cpld_ram_multipage
   import cpld_ram_pkg::*;
#(
   parameter int NUM_PAGES = 2,
   parameter int OVERDRIVE = 1,
   parameter int WR_EXT    = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   cpld_ram_multipage_if.slave  bus
);

   localparam int PB = pb_of(NUM_PAGES);
   localparam int PW = (PB > 0) ? PB : 1;
   localparam int AW = 5 + PB;
   localparam logic OD_EN = (OVERDRIVE != 0);

   state_t            r_state;
   logic [1:0]        r_hold;
   logic              r_mreq_q;
   logic              r_iowr_q;
   logic              r_a15;
   logic [PW-1:0]     r_page;
   logic [BANK_W-1:0] r_bank;
   logic [2:0]        r_mode;
   logic [AW-1:0]     r_ramadrhi;
   logic              r_ramcs_b;
   logic              r_ramdis;
   logic              r_rd_b_od;
   logic              r_adr15_od;

   logic              w_iowr;
   logic              w_start;
   logic              w_cyc;
   logic              w_hit;
   logic              w_a15od;
   logic [AW-1:0]     w_adrhi;
   logic [PW-1:0]     w_new_page;
   logic              w_unused_bus;

   assign w_iowr = !bus.iorq_b && !bus.wr_b && bus.m1_b
                && !bus.adr[15] && (&bus.data[7:6])
                && (&bus.adr[14:8+PB]);

   // IO cycles take priority: a memory cycle only starts with iorq_b high
   assign w_start = !bus.mreq_b && r_mreq_q && bus.rfsh_b
                 && bus.iorq_b;

   assign w_cyc = (r_state == ST_MRD) || (r_state == ST_MWR);

   assign w_unused_bus = &{1'b0, bus.adr[7:0], bus.rd_b};

   generate
      if (PB > 0) begin : g_pg
         assign w_new_page = ~bus.adr[8 +: PB];
         assign bus.cfg_q  = {r_page, r_bank, r_mode};
      end else begin : g_nopg
         assign w_new_page = 1'b0;
         assign bus.cfg_q  = {r_bank, r_mode};
      end
   endgenerate

   cpld_ram_bank_decode #(.PB(PB)) u_dec (
      .i_mode   (r_mode),
      .i_bank   (r_bank),
      .i_page   (r_page),
      .i_a15    (r_a15),
      .i_a14    (bus.adr[14]),
      .o_hit    (w_hit),
      .o_adrhi  (w_adrhi),
      .o_a15_od (w_a15od)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_hold     <= '0;
         r_mreq_q   <= 1'b1;
         r_iowr_q   <= 1'b0;
         r_a15      <= 1'b0;
         r_page     <= '0;
         r_bank     <= '0;
         r_mode     <= '0;
         r_ramadrhi <= '0;
         r_ramcs_b  <= 1'b1;
         r_ramdis   <= 1'b0;
         r_rd_b_od  <= 1'b0;
         r_adr15_od <= 1'b0;
      end else begin
         r_mreq_q <= bus.mreq_b;
         r_iowr_q <= w_iowr;

         // capture only on the first clk of the IO write
         if (w_iowr && !r_iowr_q) begin
            r_page <= w_new_page;
            r_bank <= bus.data[5:3];
            r_mode <= bus.data[2:0];
         end

         unique case (r_state)
            ST_IDLE: begin
               if (w_start) begin
                  r_a15   <= bus.adr[15];
                  r_state <= bus.wr_b ? ST_MRD : ST_MWR;
               end
            end
            ST_MRD: begin
               if (bus.mreq_b)
                  r_state <= ST_IDLE;
               else if (!bus.wr_b)
                  r_state <= ST_MWR;
            end
            ST_MWR: begin
               if (bus.mreq_b) begin
                  if (WR_EXT > 0) begin
                     r_state <= ST_HOLD;
                     r_hold  <= 2'(WR_EXT - 1);
                  end else begin
                     r_state <= ST_IDLE;
                  end
               end
            end
            ST_HOLD: begin
               if (r_hold == 2'd0)
                  r_state <= ST_IDLE;
               else
                  r_hold <= r_hold - 2'd1;
            end
         endcase

         r_ramcs_b <= !(w_cyc && w_hit);
         r_ramdis  <= w_cyc && w_hit;
         if (w_cyc && w_hit)
            r_ramadrhi <= w_adrhi;
         // HOLD keeps whatever the write phase decided
         r_rd_b_od  <= OD_EN && (((r_state == ST_MWR) && w_hit)
                    || ((r_state == ST_HOLD) && r_rd_b_od));
         r_adr15_od <= OD_EN && w_cyc && w_a15od;
      end
   end

   assign bus.ramadrhi = r_ramadrhi;
   assign bus.ramcs_b  = r_ramcs_b;
   assign bus.ramdis   = r_ramdis;
   assign bus.rd_b_od  = r_rd_b_od;
   assign bus.adr15_od = r_adr15_od;

endmodule
